// File: rtl/cluster_timer_arb_pkg.sv
// cluster_timer_arb_pkg: shared defaults, bundle types and width helper for the timer peripheral arbiter.
package cluster_timer_arb_pkg;

    localparam int NB_MASTERS_DEF = 4;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int IDX_W          = $clog2(NB_MASTERS_DEF);

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0]   add;
        logic                        wen;
        logic [DATA_WIDTH_DEF-1:0]   wdata;
        logic [DATA_WIDTH_DEF/8-1:0] be;
    } req_bundle_t;

    typedef struct packed {
        logic                      opc;
        logic [DATA_WIDTH_DEF-1:0] rdata;
    } rsp_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cluster_timer_arb_idx_fifo.sv
// cluster_timer_arb_idx_fifo: in-order FIFO of granted master indices, head is the next response owner.
module cluster_timer_arb_idx_fifo
    import cluster_timer_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = idx_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_q, wr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_q];
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= do_pop ? ptr_next(rd_q) : rd_q;
            wr_q    <= do_push ? ptr_next(wr_q) : wr_q;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_q] <= wdata;
    end

endmodule

// File: rtl/cluster_timer_periph_arb.sv
// cluster_timer_periph_arb: round-robin arbiter sharing the cluster timer slave port,
// routing in-order responses back to their issuing master and flagging protocol errors.
module cluster_timer_periph_arb
    import cluster_timer_arb_pkg::*;
#(
    parameter int NB_MASTERS      = NB_MASTERS_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int ID_WIDTH        = IDX_W,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NB_MASTERS-1:0]             m_req_i,
    input  logic [NB_MASTERS*ADDR_WIDTH-1:0]  m_add_i,
    input  logic [NB_MASTERS-1:0]             m_wen_i,
    input  logic [NB_MASTERS*DATA_WIDTH-1:0]  m_wdata_i,
    input  logic [NB_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
    output logic [NB_MASTERS-1:0]             m_gnt_o,
    output logic [NB_MASTERS-1:0]             m_r_valid_o,
    output logic                              m_r_opc_o,
    output logic [DATA_WIDTH-1:0]             m_r_rdata_o,
    output logic                              s_req_o,
    output logic [ADDR_WIDTH-1:0]             s_add_o,
    output logic                              s_wen_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]           s_be_o,
    output logic [ID_WIDTH-1:0]               s_id_o,
    input  logic                              s_gnt_i,
    input  logic                              s_r_valid_i,
    input  logic                              s_r_opc_i,
    input  logic [ID_WIDTH-1:0]               s_r_id_i,
    input  logic [DATA_WIDTH-1:0]             s_r_rdata_i,
    output logic                              err_o
);

    localparam int IW = idx_width(NB_MASTERS);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    if (ID_WIDTH < $clog2(NB_MASTERS)) begin : g_id_chk
        $error("ID_WIDTH too narrow for NB_MASTERS");
    end
    if (NB_MASTERS < 2 || MAX_OUTSTANDING < 1) begin : g_param_chk
        $error("NB_MASTERS must be >= 2 and MAX_OUTSTANDING >= 1");
    end

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] add;
        logic                  wen;
        logic [DATA_WIDTH-1:0] wdata;
        logic [BW-1:0]         be;
    } req_t;

    req_t          reqs [NB_MASTERS];
    req_t          sel;
    logic [IW-1:0] rr_ptr_q, winner, cand, head;
    logic [CW-1:0] count;
    logic          found, any_req, credit_ok, hs, pop, full, empty, err_q;

    for (genvar g = 0; g < NB_MASTERS; g++) begin : g_req
        assign reqs[g] = '{add:   m_add_i[g*ADDR_WIDTH +: ADDR_WIDTH],
                           wen:   m_wen_i[g],
                           wdata: m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH],
                           be:    m_be_i[g*BW +: BW]};
    end

    // first requester at or above rr_ptr_q, wrapping modulo NB_MASTERS
    always_comb begin
        winner = rr_ptr_q;
        cand   = rr_ptr_q;
        found  = 1'b0;
        for (int k = 0; k < NB_MASTERS; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % NB_MASTERS);
            if (!found && m_req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // a response popping this cycle frees a slot for the same-cycle grant
    assign credit_ok = (count < CW'(MAX_OUTSTANDING)) | (full & s_r_valid_i);
    assign any_req   = |m_req_i;
    assign s_req_o   = any_req & credit_ok;
    assign hs        = s_req_o & s_gnt_i;
    assign pop       = s_r_valid_i & ~empty;
    assign sel       = any_req ? reqs[winner] : '0;

    assign s_add_o     = sel.add;
    assign s_wen_o     = sel.wen;
    assign s_wdata_o   = sel.wdata;
    assign s_be_o      = sel.be;
    assign s_id_o      = any_req ? ID_WIDTH'(winner) : '0;
    assign m_gnt_o     = hs ? NB_MASTERS'(1) << winner : '0;
    assign m_r_valid_o = pop ? NB_MASTERS'(1) << head : '0;
    assign m_r_opc_o   = s_r_opc_i;
    assign m_r_rdata_o = s_r_rdata_i;
    assign err_o       = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (hs) rr_ptr_q <= (winner == IW'(NB_MASTERS - 1)) ? '0 : winner + 1'b1;
            // the FIFO head stays authoritative; a mismatched or orphan response is only flagged
            err_q <= err_q | (s_r_valid_i & (empty | (s_r_id_i != ID_WIDTH'(head))));
        end
    end

    cluster_timer_arb_idx_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IW),
        .CW    (CW)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (hs),
        .wdata  (winner),
        .pop    (s_r_valid_i),
        .head   (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: doc/cluster_timer_periph_arb.md
Name: cluster_timer_periph_arb

Overview:
Round-robin arbiter that shares the single cluster timer peripheral slave port between NB_MASTERS requesters (cores, event unit, debug). It sits between the per-master peripheral request lines and the timer wrapper's req/gnt/r_valid interface. It grants at most one request per cycle and tracks outstanding transactions in an in-order index FIFO. It returns each response to the master that issued it and flags protocol violations.

Parameters:
NB_MASTERS, 4, number of requesters (>=2)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
ID_WIDTH, 2, slave id width; elaboration error if ID_WIDTH < $clog2(NB_MASTERS)
MAX_OUTSTANDING, 2, depth of the outstanding-index FIFO (>=1)

Ports:
clk_i  in  1  cluster clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  NB_MASTERS  per-master request
m_add_i  in  NB_MASTERS x ADDR_WIDTH  per-master address
m_wen_i  in  NB_MASTERS  per-master write-enable-n (1 = read)
m_wdata_i  in  NB_MASTERS x DATA_WIDTH  per-master write data
m_be_i  in  NB_MASTERS x DATA_WIDTH/8  per-master byte enables
m_gnt_o  out  NB_MASTERS  per-master grant
m_r_valid_o  out  NB_MASTERS  per-master response valid
m_r_opc_o  out  1  response opcode/error, broadcast
m_r_rdata_o  out  DATA_WIDTH  response data, broadcast
s_req_o  out  1  request to timer
s_add_o  out  ADDR_WIDTH  muxed address
s_wen_o  out  1  muxed wen
s_wdata_o  out  DATA_WIDTH  muxed write data
s_be_o  out  DATA_WIDTH/8  muxed byte enables
s_id_o  out  ID_WIDTH  winner index, zero-extended
s_gnt_i  in  1  timer grant
s_r_valid_i  in  1  timer response valid
s_r_opc_i  in  1  timer response opcode
s_r_id_i  in  ID_WIDTH  timer response id
s_r_rdata_i  in  DATA_WIDTH  timer response data
err_o  out  1  sticky protocol error

Behaviour:
- One clock domain, clk_i. Reset rst_ni is asynchronous and active-low. All state is cleared on reset.
- Reset values: rr_ptr_q=0, FIFO empty (count 0), err_o=0.
- All other outputs are combinational. With no requests they are 0: s_req_o=0, m_gnt_o=0, m_r_valid_o=0.
- Credit: credit_ok = (count < MAX_OUTSTANDING) OR (count == MAX_OUTSTANDING AND s_r_valid_i). A same-cycle pop frees a slot.
- Arbitration: the winner is the first asserted m_req_i scanning from rr_ptr_q upward, with modulo-NB_MASTERS wrap.
- s_req_o = |m_req_i AND credit_ok. The slave data/id outputs mux the winner's fields. s_id_o = winner index.
- m_gnt_o[winner] = s_req_o AND s_gnt_i. All other grants are 0. Zero-latency grant, same cycle.
- On handshake (s_req_o AND s_gnt_i):
  - rr_ptr_q <= (winner+1) mod NB_MASTERS.
  - Push the winner index into the FIFO.
- Without a handshake, rr_ptr_q holds, so a stalled winner keeps priority and its request fields stay muxed.
- Response (s_r_valid_i, FIFO non-empty): m_r_valid_o[head]=1 in the same cycle. rdata/opc are passed through. Pop the head.
- Simultaneous push and pop: count unchanged, head advances, new entry is written at the tail.
- s_r_valid_i with FIFO empty: no master valid, no pop, err_o <= 1.
- s_r_valid_i with s_r_id_i != zero-extended head: still routed by FIFO head (in-order is authoritative), err_o <= 1.
- err_o is sticky until reset.
- Wrap-around: FIFO pointers wrap mod MAX_OUTSTANDING. rr_ptr wraps at NB_MASTERS-1 -> 0.
- Reset mid-transaction: outstanding entries are discarded. Responses arriving after reset set err_o.
- Master-side rule (not checked): a master holds req and fields stable until gnt.

Decomposition:
- Package cluster_timer_arb_pkg holds:
  - localparam IDX_W = $clog2(NB_MASTERS) default helper.
  - typedef for the request bundle struct (add, wen, wdata, be).
  - typedef for the response struct (opc, rdata).
- One sub-module: cluster_timer_arb_idx_fifo, a parameterized depth/width in-order index FIFO exposing push, pop, head, count, full, empty.
- Round-robin priority scan stays inline.

Test Plan:
- Reset, then master 2 read at 0x04; slave gnt=1, r_valid next cycle with rdata=0x1234, r_id=2 -> s_id_o=2, m_gnt_o=4'b0100, m_r_valid_o[2]=1, rdata=0x1234, err_o=0.
- All 4 masters request continuously; slave always grants, replies 1 cycle later -> grants in order 0,1,2,3,0. No master is granted twice before all others are served.
- MAX_OUTSTANDING=2, slave grants every cycle, response delayed 3 cycles:
  - Third request is stalled (s_req_o=0) until the first r_valid.
  - In the r_valid cycle a new grant is accepted (pop+push).
  - count never exceeds 2.
- Slave holds gnt=0 for 5 cycles while masters 1 and 3 request -> s_id_o stays 1, rr_ptr unchanged. Once gnt rises, master 1 is granted, then master 3.
- Inject r_valid with FIFO empty -> all m_r_valid_o=0, err_o=1 next cycle and stays 1 until rst_ni asserted low.
- Outstanding head=1 but r_id=3 -> m_r_valid_o[1]=1, err_o=1. Assert rst_ni low mid-stream -> count=0, rr_ptr=0, err_o=0 immediately (async).
